// File: rtl/mult_accum_pkg.sv
// mult_accum_pkg: shared constants and product extension helper for the multiplier accumulator stage
package mult_accum_pkg;
  localparam int LATENCY = 4;
  localparam int OUT_DEPTH = 2;
  function automatic logic [63:0] ext_product(input logic [63:0] prod, input logic tc, input int width);
    return (tc && prod[6'(width - 1)]) ? (prod | ({64{1'b1}} << width)) : prod;
  endfunction
endpackage

// File: rtl/mult_accum_delay_line.sv
// mult_accum_delay_line: LATENCY-deep {valid,last,tc} tracker aligned with the multiplier (CLK,RST,in_* -> d_*, busy)
module mult_accum_delay_line
  import mult_accum_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic in_valid,
  input  logic in_last,
  input  logic in_tc,
  output logic d_valid,
  output logic d_last,
  output logic d_tc,
  output logic busy
);
  logic [LATENCY-1:0] v, l, t;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      v <= '0;
      l <= '0;
      t <= '0;
    end else begin
      v <= {v[LATENCY-2:0], in_valid};
      l <= {l[LATENCY-2:0], in_last};
      t <= {t[LATENCY-2:0], in_tc};
    end
  assign d_valid = v[LATENCY-1];
  assign d_last = l[LATENCY-1];
  assign d_tc = t[LATENCY-1];
  assign busy = |v;
endmodule

// File: rtl/mult_accum_stage.sv
// mult_accum_stage: per-group product accumulator behind a 4-edge multiplier (IN_* handshake, PRODUCT in, OUT_* 2-entry result buffer, BUSY)
module mult_accum_stage
  import mult_accum_pkg::*;
#(
  parameter int A_width = 8,
  parameter int B_width = 8,
  parameter int GUARD_BITS = 8,
  parameter int CNT_width = 8
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic                                    IN_VALID,
  output logic                                    IN_READY,
  input  logic                                    IN_LAST,
  input  logic                                    IN_TC,
  input  logic [A_width+B_width-1:0]              PRODUCT,
  output logic                                    OUT_VALID,
  input  logic                                    OUT_READY,
  output logic [A_width+B_width+GUARD_BITS-1:0]   OUT_ACC,
  output logic                                    OUT_OVF,
  output logic [CNT_width-1:0]                    OUT_COUNT,
  output logic                                    BUSY
);
  localparam int P_W = A_width + B_width;
  localparam int ACC_W = P_W + GUARD_BITS;
  logic d_valid, d_last, d_tc, dl_busy;
  logic [ACC_W-1:0] acc, base, ext, sum, push_acc;
  logic [ACC_W:0] sum_c;
  logic ovf, ovf_now, ovf_n, first, push_r, push_ovf, wr_ptr, rd_ptr, accept, pop;
  logic [CNT_width-1:0] cnt, cnt_n, push_cnt;
  logic [1:0] credits, fifo_n;
  logic [ACC_W-1:0] f_acc [OUT_DEPTH];
  logic f_ovf [OUT_DEPTH];
  logic [CNT_width-1:0] f_cnt [OUT_DEPTH];
  mult_accum_delay_line u_dl (
    .CLK(CLK), .RST(RST), .in_valid(accept), .in_last(IN_LAST), .in_tc(IN_TC),
    .d_valid(d_valid), .d_last(d_last), .d_tc(d_tc), .busy(dl_busy)
  );
  assign IN_READY = credits < 2'(OUT_DEPTH);
  assign accept = IN_VALID & IN_READY;
  assign OUT_VALID = fifo_n != 2'd0;
  assign pop = OUT_VALID & OUT_READY;
  assign OUT_ACC = f_acc[rd_ptr];
  assign OUT_OVF = f_ovf[rd_ptr];
  assign OUT_COUNT = f_cnt[rd_ptr];
  assign BUSY = dl_busy | !first | push_r | OUT_VALID;
  always_comb begin
    base = first ? '0 : acc;
    ext = ACC_W'(ext_product(64'(PRODUCT), d_tc, P_W));
    sum_c = {1'b0, base} + {1'b0, ext};
    sum = sum_c[ACC_W-1:0];
    ovf_now = d_tc ? (base[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]) : sum_c[ACC_W];
    ovf_n = (!first & ovf) | ovf_now;
    cnt_n = first ? CNT_width'(1) : (&cnt ? cnt : cnt + 1'b1);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
      first <= 1'b1;
      push_r <= 1'b0;
      push_acc <= '0;
      push_ovf <= 1'b0;
      push_cnt <= '0;
      credits <= '0;
      fifo_n <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        f_acc[i] <= '0;
        f_ovf[i] <= 1'b0;
        f_cnt[i] <= '0;
      end
    end else begin
      if (d_valid) begin
        acc <= d_last ? '0 : sum;
        ovf <= ovf_n;
        cnt <= cnt_n;
        first <= d_last;
        push_acc <= sum;
        push_ovf <= ovf_n;
        push_cnt <= cnt_n;
      end
      push_r <= d_valid & d_last;
      credits <= credits + 2'(accept & IN_LAST) - 2'(pop);
      fifo_n <= fifo_n + 2'(push_r) - 2'(pop);
      if (push_r) begin
        f_acc[wr_ptr] <= push_acc;
        f_ovf[wr_ptr] <= push_ovf;
        f_cnt[wr_ptr] <= push_cnt;
        wr_ptr <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
    end
endmodule

// File: tb/tb_mult_accum_stage.sv
// tb_mult_accum_stage: scoreboard bench driving two accumulator instances (24-bit and 16-bit) behind a modelled 4-edge multiplier
`timescale 1ns/1ps
module tb_mult_accum_stage;
  typedef struct {
    logic [23:0] a24;
    logic        o24;
    logic [15:0] a16;
    logic        o16;
    logic [7:0]  cnt;
  } exp_t;
  logic CLK = 0, RST = 1, IN_VALID = 0, IN_LAST = 0, IN_TC = 0, OUT_READY = 1;
  logic [7:0] a = 0, b = 0;
  logic [15:0] pipe [4];
  logic [15:0] PRODUCT, up, mult_in;
  logic signed [15:0] sp;
  logic rdy0, ov0, ovf0, busy0, rdy1, ov1, ovf1, busy1;
  logic [23:0] acc0;
  logic [15:0] acc1;
  logic [7:0] cnt0, cnt1;
  int n_cmp = 0, n_err = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  always #5 CLK = ~CLK;
  assign sp = $signed(a) * $signed(b);
  assign up = {8'h0, a} * {8'h0, b};
  assign mult_in = IN_TC ? sp : up;
  assign PRODUCT = pipe[3];
  always @(posedge CLK) begin
    pipe[0] <= mult_in;
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end
  mult_accum_stage #(.A_width(8), .B_width(8), .GUARD_BITS(8), .CNT_width(8)) u0 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(rdy0), .IN_LAST(IN_LAST), .IN_TC(IN_TC),
    .PRODUCT(PRODUCT), .OUT_VALID(ov0), .OUT_READY(OUT_READY), .OUT_ACC(acc0), .OUT_OVF(ovf0),
    .OUT_COUNT(cnt0), .BUSY(busy0)
  );
  mult_accum_stage #(.A_width(8), .B_width(8), .GUARD_BITS(0), .CNT_width(8)) u1 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(rdy1), .IN_LAST(IN_LAST), .IN_TC(IN_TC),
    .PRODUCT(PRODUCT), .OUT_VALID(ov1), .OUT_READY(OUT_READY), .OUT_ACC(acc1), .OUT_OVF(ovf1),
    .OUT_COUNT(cnt1), .BUSY(busy1)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge CLK)
    if (ov0 && OUT_READY) begin
      if (q0.size() == 0) check("u0 unexpected result", {8'h0, acc0}, 32'hFFFF_FFFF);
      else begin
        e0 = q0.pop_front();
        check("u0 acc", {8'h0, acc0}, {8'h0, e0.a24});
        check("u0 ovf", {31'h0, ovf0}, {31'h0, e0.o24});
        check("u0 count", {24'h0, cnt0}, {24'h0, e0.cnt});
      end
    end
  always @(negedge CLK)
    if (ov1 && OUT_READY) begin
      if (q1.size() == 0) check("u1 unexpected result", {16'h0, acc1}, 32'hFFFF_FFFF);
      else begin
        e1 = q1.pop_front();
        check("u1 acc", {16'h0, acc1}, {16'h0, e1.a16});
        check("u1 ovf", {31'h0, ovf1}, {31'h0, e1.o16});
        check("u1 count", {24'h0, cnt1}, {24'h0, e1.cnt});
      end
    end
  task automatic expect_res(input logic [23:0] a24, input logic o24, input logic [15:0] a16,
                            input logic o16, input logic [7:0] c);
    exp_t e;
    e.a24 = a24; e.o24 = o24; e.a16 = a16; e.o16 = o16; e.cnt = c;
    q0.push_back(e);
    q1.push_back(e);
  endtask
  task automatic beat(input logic [7:0] av, input logic [7:0] bv, input logic tc, input logic last);
    int k;
    a = av; b = bv; IN_TC = tc; IN_LAST = last; IN_VALID = 1;
    for (k = 0; k < 100 && !rdy0; k++) @(negedge CLK);
    if (!rdy0) check("beat accept timeout", 32'h0, 32'h1);
    else @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 0; IN_LAST = 0;
  endtask
  task automatic set_ready(input logic v);
    @(posedge CLK);
    #1 OUT_READY = v;
    @(negedge CLK);
  endtask
  task automatic drain();
    int k;
    for (k = 0; k < 100 && (busy0 || busy1); k++) @(negedge CLK);
    check("drain busy", {31'h0, busy0 | busy1}, 32'h0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge CLK);
    check("reset in_ready", {31'h0, rdy0}, 32'h1);
    check("reset out_valid", {31'h0, ov0}, 32'h0);
    check("reset out_acc", {8'h0, acc0}, 32'h0);
    check("reset out_ovf", {31'h0, ovf0}, 32'h0);
    check("reset out_count", {24'h0, cnt0}, 32'h0);
    check("reset busy", {31'h0, busy0}, 32'h0);
    RST = 0;
    @(negedge CLK);
    expect_res(24'h00000F, 1'b0, 16'h000F, 1'b0, 8'd1);
    beat(8'd3, 8'd5, 1'b0, 1'b1);
    repeat (4) @(negedge CLK);
    check("latency edge4 out_valid", {31'h0, ov0}, 32'h0);
    @(negedge CLK);
    check("latency edge5 out_valid", {31'h0, ov0}, 32'h1);
    drain();
    expect_res(24'hFFFFEF, 1'b0, 16'hFFEF, 1'b0, 8'd2);
    beat(8'hFD, 8'd7, 1'b1, 1'b0);
    beat(8'd2, 8'd2, 1'b1, 1'b1);
    drain();
    expect_res(24'h01FC02, 1'b0, 16'hFC02, 1'b1, 8'd2);
    beat(8'd255, 8'd255, 1'b0, 1'b0);
    beat(8'd255, 8'd255, 1'b0, 1'b1);
    drain();
    set_ready(1'b0);
    expect_res(24'd1, 1'b0, 16'd1, 1'b0, 8'd1);
    expect_res(24'd4, 1'b0, 16'd4, 1'b0, 8'd1);
    expect_res(24'd9, 1'b0, 16'd9, 1'b0, 8'd1);
    beat(8'd1, 8'd1, 1'b0, 1'b1);
    beat(8'd2, 8'd2, 1'b0, 1'b1);
    check("two credits in_ready", {31'h0, rdy0}, 32'h0);
    repeat (8) @(negedge CLK);
    check("stalled out_valid", {31'h0, ov0}, 32'h1);
    check("stalled out_acc hold", {8'h0, acc0}, 32'd1);
    check("stalled in_ready", {31'h0, rdy0}, 32'h0);
    set_ready(1'b1);
    beat(8'd3, 8'd3, 1'b0, 1'b1);
    drain();
    beat(8'd1, 8'd1, 1'b0, 1'b0);
    beat(8'd1, 8'd1, 1'b0, 1'b0);
    RST = 1;
    @(negedge CLK);
    check("mid reset busy", {31'h0, busy0}, 32'h0);
    check("mid reset in_ready", {31'h0, rdy0}, 32'h1);
    check("mid reset out_valid", {31'h0, ov0}, 32'h0);
    RST = 0;
    repeat (8) @(negedge CLK);
    check("aborted group out_valid", {31'h0, ov0 | ov1}, 32'h0);
    expect_res(24'd4, 1'b0, 16'd4, 1'b0, 8'd1);
    beat(8'd2, 8'd2, 1'b0, 1'b1);
    drain();
    set_ready(1'b0);
    expect_res(24'd25, 1'b0, 16'd25, 1'b0, 8'd1);
    expect_res(24'd36, 1'b0, 16'd36, 1'b0, 8'd1);
    beat(8'd5, 8'd5, 1'b0, 1'b1);
    for (int k = 0; k < 20 && !ov0; k++) @(negedge CLK);
    check("one credit out_valid", {31'h0, ov0}, 32'h1);
    check("one credit in_ready", {31'h0, rdy0}, 32'h1);
    set_ready(1'b1);
    beat(8'd6, 8'd6, 1'b0, 1'b1);
    check("pop+last in_ready", {31'h0, rdy0}, 32'h1);
    check("pop+last out_valid", {31'h0, ov0}, 32'h0);
    drain();
    check("u0 results pending", q0.size(), 32'd0);
    check("u1 results pending", q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
